sram_arbiter: RTL and testbench

- Shares the single SRAM controller port (mem/rw/ready/addr/data2ram/data2fpga) between two requesters.
- Requester V is the NTSC video line fetch: read-only, high priority.
- Requester C is the CPU/test port: read/write.
- Sits between the clients and the SRAM controller. It sequences one controller transaction at a time and returns read data and completion to the granted client.

---
 rtl/sram_arb_pkg.sv | 26 ++
 rtl/sram_arb_port.sv | 33 +++
 rtl/sram_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-client SRAM arbiter.
// Video (V) is read-only and high priority; CPU (C) may read or write.
package sram_arb_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;

    localparam logic SEL_VID = 1'b0;
    localparam logic SEL_CPU = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LO,
        WAIT_HI,
        DONE,
        ABORT
    } state_t;

    // Latched request: rw (1 = read), address, write data.
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sram_arb_port.sv
// One requester slot: a pending flag plus the latched request.
// A strobe is dropped while pending, except in the cycle the slot completes.
module sram_arb_port
    import sram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              done,
    output logic              pend,
    output req_t              lat
);

    logic take;

    assign take = req && (!pend || done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
            lat  <= '0;
        end else if (take) begin
            pend <= 1'b1;
            lat  <= '{rw: req_rw, addr: req_addr, wdata: req_wdata};
        end else if (done) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller port between the video fetch and the CPU port,
// running one controller transaction at a time with a bounded video burst.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int VID_BURST_MAX = 4,
    parameter int TIMEOUT       = 15
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              err,
    output logic              mem,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data2ram,
    input  logic              ready,
    input  logic [DATA_W-1:0] data2fpga
);

    localparam int BW = $clog2(VID_BURST_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] BURST_LIM = BW'(VID_BURST_MAX);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    state_t          state;
    state_t          state_nx;
    logic            sel;
    logic            sel_nx;
    logic [BW-1:0]   burst;
    logic [TW-1:0]   timer;

    logic            vid_pend;
    logic            cpu_pend;
    req_t            vid_lat;
    req_t            cpu_lat;
    req_t            win;
    req_t            hold;

    logic            grant_cpu;
    logic            issue;
    logic            finish;
    logic            capture;

    sram_arb_port u_vid (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (vid_req),
        .req_rw    (1'b1),
        .req_addr  (vid_addr),
        .req_wdata ('0),
        .done      (vid_ack),
        .pend      (vid_pend),
        .lat       (vid_lat)
    );

    sram_arb_port u_cpu (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (cpu_req),
        .req_rw    (cpu_rw),
        .req_addr  (cpu_addr),
        .req_wdata (cpu_wdata),
        .done      (cpu_ack),
        .pend      (cpu_pend),
        .lat       (cpu_lat)
    );

    // Video wins unless it has used up its burst while the CPU waits.
    assign grant_cpu = cpu_pend && (!vid_pend || burst == BURST_LIM);
    assign win       = grant_cpu ? cpu_lat : vid_lat;

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        issue    = 1'b0;
        unique case (state)
            IDLE: begin
                if (ready && (vid_pend || cpu_pend)) begin
                    issue    = 1'b1;
                    sel_nx   = grant_cpu ? SEL_CPU : SEL_VID;
                    state_nx = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!ready) begin
                    state_nx = WAIT_HI;
                end else if (timer == TMO_LAST) begin
                    state_nx = ABORT;
                end
            end
            WAIT_HI: begin
                if (ready) begin
                    state_nx = DONE;
                end else if (timer == TMO_LAST) begin
                    state_nx = ABORT;
                end
            end
            DONE:    state_nx = IDLE;
            ABORT:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign finish  = (state == DONE) || (state == ABORT);
    assign capture = (state == WAIT_HI) && ready;

    assign mem     = issue;
    assign vid_ack = finish && (sel == SEL_VID);
    assign cpu_ack = finish && (sel == SEL_CPU);

    // The command is driven straight from the winner's latch in the mem
    // cycle, then held from the registered copy until the next issue.
    assign {rw, addr, data2ram} = issue ? win : hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= SEL_VID;
            hold  <= '0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            if (issue) begin
                hold <= win;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state_nx != state) begin
            timer <= '0;
        end else if (state == WAIT_LO || state == WAIT_HI) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst <= '0;
        end else if (issue) begin
            if (grant_cpu) begin
                burst <= '0;
            end else if (cpu_pend && burst != BURST_LIM) begin
                burst <= burst + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state_nx == ABORT) begin
            err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid_rdata <= '0;
            cpu_rdata <= '0;
        end else if (capture) begin
            if (sel == SEL_VID) begin
                vid_rdata <= data2fpga;
            end else if (hold.rw) begin
                cpu_rdata <= data2fpga;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed vectors, corner sequences and a
// randomized run checked against a transaction-level model.
module tb_sram_arbiter;

    localparam int VMAX = 4;
    localparam int TMO  = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vid_req = 1'b0;
    logic [19:0] vid_addr = '0;
    logic        vid_ack;
    logic [7:0]  vid_rdata;
    logic        cpu_req = 1'b0;
    logic        cpu_rw = 1'b0;
    logic [19:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        err;
    logic        mem;
    logic        rw;
    logic [19:0] addr;
    logic [7:0]  data2ram;
    logic        ready;
    logic [7:0]  data2fpga;

    sram_arbiter #(.VID_BURST_MAX(VMAX), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_ack   (vid_ack),
        .vid_rdata (vid_rdata),
        .cpu_req   (cpu_req),
        .cpu_rw    (cpu_rw),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .err       (err),
        .mem       (mem),
        .rw        (rw),
        .addr      (addr),
        .data2ram  (data2ram),
        .ready     (ready),
        .data2fpga (data2fpga)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM controller model: ready falls one cycle after mem, stays low
    // for lo_cnt cycles, then returns with read data.
    logic [7:0] sram [256];
    bit         sram_init;
    bit         stuck;
    bit         rnd_lat;
    int         lo_cnt;
    logic [7:0] c_idx;

    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 256; i++) sram[i] <= 8'(i * 7 + 3);
            sram_init <= 1'b1;
            ready     <= 1'b1;
            data2fpga <= '0;
            lo_cnt    <= 0;
            c_idx     <= '0;
        end else if (mem && ready && !stuck) begin
            ready  <= 1'b0;
            lo_cnt <= rnd_lat ? int'($urandom_range(5, 1)) : 3;
            c_idx  <= addr[7:0];
            if (!rw) sram[addr[7:0]] <= data2ram;
        end else if (!ready) begin
            if (lo_cnt <= 1) begin
                ready     <= 1'b1;
                data2fpga <= sram[c_idx];
            end else begin
                lo_cnt <= lo_cnt - 1;
            end
        end
    end

    int nvec;
    int nerr;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Event log and transaction-level reference model
    int          mem_cnt, vack_cnt, cack_cnt, vack_cyc, cack_cyc;
    logic [19:0] mem_q [$];
    logic [19:0] l_addr;
    logic        l_rw;
    logic [7:0]  l_wd;
    bit          mdl_on;
    logic [7:0]  msram [256];
    bit          m_vp, m_cp, m_crw, m_cur_cpu;
    logic [19:0] m_va, m_ca;
    logic [7:0]  m_cd, m_exp;
    int          m_burst, m_acc, m_done;

    task automatic model_step();
        bit g;
        if (mem) begin
            chk("rnd_mem_has_pending", 32'(m_vp || m_cp), 1);
            g = m_cp && (!m_vp || m_burst == VMAX);
            if (g) begin
                chk("rnd_cpu_addr", 32'(addr), 32'(m_ca));
                chk("rnd_cpu_rw", 32'(rw), 32'(m_crw));
                if (!m_crw) chk("rnd_cpu_wdata", 32'(data2ram), 32'(m_cd));
                m_exp = msram[m_ca[7:0]];
                if (!m_crw) msram[m_ca[7:0]] = m_cd;
                m_burst = 0;
            end else begin
                chk("rnd_vid_addr", 32'(addr), 32'(m_va));
                chk("rnd_vid_rw", 32'(rw), 1);
                m_exp = msram[m_va[7:0]];
                if (m_cp && m_burst < VMAX) m_burst++;
            end
            m_cur_cpu = g;
        end
        if (vid_ack) begin
            chk("rnd_vid_ack_owner", 32'(m_cur_cpu), 0);
            chk("rnd_vid_rdata", 32'(vid_rdata), 32'(m_exp));
            m_vp = 1'b0;
            m_done++;
        end
        if (cpu_ack) begin
            chk("rnd_cpu_ack_owner", 32'(m_cur_cpu), 1);
            if (m_crw) chk("rnd_cpu_rdata", 32'(cpu_rdata), 32'(m_exp));
            m_cp = 1'b0;
            m_done++;
        end
        if (vid_req && !m_vp) begin
            m_vp = 1'b1;
            m_va = vid_addr;
            m_acc++;
        end
        if (cpu_req && !m_cp) begin
            m_cp  = 1'b1;
            m_ca  = cpu_addr;
            m_crw = cpu_rw;
            m_cd  = cpu_wdata;
            m_acc++;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem) begin
                    mem_cnt++;
                    mem_q.push_back(addr);
                    l_addr = addr;
                    l_rw   = rw;
                    l_wd   = data2ram;
                end
                if (vid_ack) begin
                    vack_cnt++;
                    vack_cyc = cyc;
                end
                if (cpu_ack) begin
                    cack_cnt++;
                    cack_cyc = cyc;
                end
                if (mdl_on) model_step();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit is_cpu, input int n0, input int lim,
                            output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            tick();
            ok = is_cpu ? (cack_cnt > n0) : (vack_cnt > n0);
        end
    endtask

    task automatic cpu_go(input bit r, input logic [19:0] a,
                          input logic [7:0] d, output int sc);
        cpu_req   = 1'b1;
        cpu_rw    = r;
        cpu_addr  = a;
        cpu_wdata = d;
        sc        = cyc;
        tick();
        cpu_req   = 1'b0;
    endtask

    task automatic vid_go(input logic [19:0] a, output int sc);
        vid_req  = 1'b1;
        vid_addr = a;
        sc       = cyc;
        tick();
        vid_req  = 1'b0;
    endtask

    typedef struct {
        bit          is_cpu;
        bit          r;
        logic [19:0] a;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;

    vec_t vt [9];

    initial begin
        int  sc, m0, v0, c0, rs;
        bit  ok;
        logic [19:0] seq [7];

        nvec = 0;
        nerr = 0;
        vt[0] = '{1, 0, 20'h00012, 8'hA5, 8'h00};
        vt[1] = '{1, 1, 20'h00012, 8'h00, 8'hA5};
        vt[2] = '{0, 1, 20'h00012, 8'h00, 8'hA5};
        vt[3] = '{1, 0, 20'hFFFFF, 8'h3C, 8'h00};
        vt[4] = '{0, 1, 20'hFFFFF, 8'h00, 8'h3C};
        vt[5] = '{1, 1, 20'hFFFFF, 8'h00, 8'h3C};
        vt[6] = '{1, 0, 20'h00000, 8'hFF, 8'h00};
        vt[7] = '{0, 1, 20'h00000, 8'h00, 8'hFF};
        vt[8] = '{0, 1, 20'h00005, 8'h00, 8'd38};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem", 32'(mem), 0);
        chk("rst_acks", 32'({vid_ack, cpu_ack}), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cmd", 32'({rw, addr, data2ram}), 0);
        chk("rst_rdata", 32'({vid_rdata, cpu_rdata}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            m0 = mem_cnt;
            v0 = vack_cnt;
            c0 = cack_cnt;
            if (vt[i].is_cpu) cpu_go(vt[i].r, vt[i].a, vt[i].d, sc);
            else vid_go(vt[i].a, sc);
            wait_ack(vt[i].is_cpu, vt[i].is_cpu ? c0 : v0, 20, ok);
            chk($sformatf("vec%0d_ack", i), 32'(ok), 1);
            if (ok) begin
                chk($sformatf("vec%0d_latency", i),
                    (vt[i].is_cpu ? cack_cyc : vack_cyc) - sc, 6);
            end
            chk($sformatf("vec%0d_mem_pulses", i), mem_cnt - m0, 1);
            chk($sformatf("vec%0d_addr", i), 32'(l_addr), 32'(vt[i].a));
            chk($sformatf("vec%0d_rw", i), 32'(l_rw), 32'(vt[i].r));
            if (vt[i].is_cpu) begin
                chk($sformatf("vec%0d_no_vack", i), vack_cnt - v0, 0);
                if (vt[i].r) begin
                    chk($sformatf("vec%0d_cpu_rdata", i), 32'(cpu_rdata),
                        32'(vt[i].exp));
                end else begin
                    chk($sformatf("vec%0d_wdata", i), 32'(l_wd), 32'(vt[i].d));
                    chk($sformatf("vec%0d_sram", i), 32'(sram[vt[i].a[7:0]]),
                        32'(vt[i].d));
                end
            end else begin
                chk($sformatf("vec%0d_no_cack", i), cack_cnt - c0, 0);
                chk($sformatf("vec%0d_vid_rdata", i), 32'(vid_rdata),
                    32'(vt[i].exp));
            end
            tick();
        end

        // Simultaneous strobes: video first, CPU right after
        m0 = mem_cnt;
        c0 = cack_cnt;
        vid_req  = 1'b1;
        vid_addr = 20'h00001;
        cpu_req  = 1'b1;
        cpu_rw   = 1'b1;
        cpu_addr = 20'h00002;
        sc = cyc;
        tick();
        vid_req = 1'b0;
        cpu_req = 1'b0;
        wait_ack(1'b1, c0, 30, ok);
        chk("simul_cpu_ack", 32'(ok), 1);
        chk("simul_vid_latency", vack_cyc - sc, 6);
        chk("simul_cpu_latency", cack_cyc - sc, 12);
        chk("simul_mem_pulses", mem_cnt - m0, 2);
        chk("simul_vid_rdata", 32'(vid_rdata), 10);
        chk("simul_cpu_rdata", 32'(cpu_rdata), 17);
        tick();

        // Burst limit: video re-requests on each ack while the CPU waits
        mem_q.delete();
        vid_req  = 1'b1;
        vid_addr = 20'h00100;
        cpu_req  = 1'b1;
        cpu_rw   = 1'b1;
        cpu_addr = 20'h00200;
        tick();
        cpu_req = 1'b0;
        rs = 5;
        for (int i = 0; i < 100; i++) begin
            vid_req = vid_ack && rs > 0;
            if (vid_req) rs--;
            tick();
        end
        vid_req = 1'b0;
        seq = '{20'h00100, 20'h00100, 20'h00100, 20'h00100,
                20'h00200, 20'h00100, 20'h00100};
        chk("burst_grant_count", mem_q.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < mem_q.size()) begin
                chk($sformatf("burst_grant%0d", i), 32'(mem_q[i]), 32'(seq[i]));
            end
        end
        chk("burst_cpu_rdata", 32'(cpu_rdata), 32'hFF);

        // Timeout: controller never drops ready
        stuck = 1'b1;
        m0 = mem_cnt;
        c0 = cack_cnt;
        chk("tmo_err_before", 32'(err), 0);
        cpu_go(1'b1, 20'h00003, 8'h00, sc);
        wait_ack(1'b1, c0, 40, ok);
        chk("tmo_ack", 32'(ok), 1);
        chk("tmo_latency", cack_cyc - sc, TMO + 2);
        chk("tmo_err", 32'(err), 1);
        chk("tmo_rdata_kept", 32'(cpu_rdata), 32'hFF);
        chk("tmo_mem_pulses", mem_cnt - m0, 1);
        stuck = 1'b0;
        tick();
        c0 = cack_cnt;
        cpu_go(1'b0, 20'h00003, 8'h77, sc);
        wait_ack(1'b1, c0, 20, ok);
        chk("post_tmo_ack", 32'(ok), 1);
        chk("post_tmo_latency", cack_cyc - sc, 6);
        chk("post_tmo_err_sticky", 32'(err), 1);
        chk("post_tmo_sram", 32'(sram[3]), 32'h77);
        tick();

        // Reset while waiting for ready to rise
        cpu_go(1'b1, 20'h00001, 8'h00, sc);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_mem", 32'(mem), 0);
        chk("midrst_acks", 32'({vid_ack, cpu_ack}), 0);
        chk("midrst_err", 32'(err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        c0 = cack_cnt;
        m0 = mem_cnt;
        repeat (10) tick();
        chk("midrst_no_ack", cack_cnt - c0, 0);
        chk("midrst_no_mem", mem_cnt - m0, 0);
        cpu_go(1'b1, 20'h00012, 8'h00, sc);
        wait_ack(1'b1, c0, 20, ok);
        chk("midrst_new_ack", 32'(ok), 1);
        chk("midrst_new_latency", cack_cyc - sc, 6);
        chk("midrst_new_rdata", 32'(cpu_rdata), 32'hA5);
        repeat (3) tick();

        // Randomized traffic against the reference model
        for (int i = 0; i < 256; i++) msram[i] = sram[i];
        m_vp = 1'b0;
        m_cp = 1'b0;
        m_burst = 0;
        m_acc = 0;
        m_done = 0;
        m_cur_cpu = 1'b0;
        rnd_lat = 1'b1;
        mdl_on = 1'b1;
        for (int i = 0; i < 600; i++) begin
            vid_req   = ($urandom % 4) == 0;
            vid_addr  = 20'($urandom);
            cpu_req   = ($urandom % 3) == 0;
            cpu_rw    = 1'($urandom);
            cpu_addr  = 20'($urandom);
            cpu_wdata = 8'($urandom);
            tick();
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
        repeat (40) tick();
        mdl_on = 1'b0;
        chk("rnd_all_served", m_done, m_acc);
        chk("rnd_none_pending", 32'({m_vp, m_cp}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
